mem_stage: RTL and testbench

Pipeline memory stage between the EXE/MEM stage register and the MEM/WB stage register. It receives the registered execute results (write-back enable, memory read/write enables, ALU result used as the address, Rm value used as store data, destination register) and holds a word-addressed data memory with a fixed access latency. While an access is in flight it deasserts `ready` so the upstream stages freeze. When the access completes, it forwards write-back control, the ALU result, load data and destination to MEM/WB.

---
 rtl/mem_pkg.sv | 7 +
 rtl/data_mem.sv | 24 ++
 rtl/mem_stage.sv | 70 +++++++
 tb/tb_mem_stage.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared state type and constants for the memory stage
package mem_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
   localparam int WORD_W = 32;
   localparam int REG_ADDR_W = 4;
   localparam int DEF_BASE_ADDR = 1024;
endpackage

// File: rtl/data_mem.sv
// data_mem: word-addressed data array with synchronous write and registered read
module data_mem
   import mem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic              ok,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we && ok) mem[addr] <= wdata;
   // out-of-range loads return zero instead of an aliased word
   always_ff @(posedge clk or negedge rst)
      if (!rst) rdata <= '0;
      else if (re) rdata <= ok ? mem[addr] : '0;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with fixed-latency data memory and upstream stall
module mem_stage
   import mem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int WAIT_CYCLES = 4,
   parameter int BASE_ADDR = DEF_BASE_ADDR
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_en_in,
   input  logic                  mem_read_en_in,
   input  logic                  mem_write_en_in,
   input  logic [WORD_W-1:0]     alu_res_in,
   input  logic [WORD_W-1:0]     val_Rm_in,
   input  logic [REG_ADDR_W-1:0] dest_in,
   output logic                  ready,
   output logic                  wb_en,
   output logic                  mem_read_en,
   output logic [WORD_W-1:0]     alu_res,
   output logic [WORD_W-1:0]     mem_data,
   output logic [REG_ADDR_W-1:0] dest,
   output logic                  addr_err
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(WAIT_CYCLES + 1);
   mem_state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [WORD_W-1:0] addr_q, wdata_q, word;
   logic wr_q, req, commit, in_range;
   assign req = mem_read_en_in | mem_write_en_in;
   assign commit = state == ACCESS && cnt == CW'(WAIT_CYCLES - 1);
   assign word = (addr_q - WORD_W'(BASE_ADDR)) >> 2;
   assign in_range = addr_q >= WORD_W'(BASE_ADDR) && word < WORD_W'(DEPTH);
   assign wb_en = wb_en_in & ready;
   assign mem_read_en = mem_read_en_in & ready;
   assign alu_res = alu_res_in;
   assign dest = dest_in;
   always_comb begin
      state_n = state == IDLE ? (req ? ACCESS : IDLE) : state == ACCESS ? (commit ? DONE : ACCESS) : IDLE;
      ready = state == DONE || (state == IDLE && !req);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         addr_err <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= state == ACCESS ? cnt + CW'(1) : '0;
         if (commit && !in_range) addr_err <= 1'b1;
      end
   // a simultaneous read and write is handled as a write
   always_ff @(posedge clk)
      if (state == IDLE && req) begin
         addr_q <= alu_res_in;
         wdata_q <= val_Rm_in;
         wr_q <= mem_write_en_in;
      end
   data_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk(clk),
      .rst(rst),
      .we(commit & wr_q),
      .re(commit & ~wr_q),
      .ok(in_range),
      .addr(word[AW-1:0]),
      .wdata(wdata_q),
      .rdata(mem_data)
   );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a behavioural memory model
module tb_mem_stage;
   localparam int W = 4, D = 64, B = 1024;
   logic clk = 0, rst = 0, wb_en_in = 0, mem_read_en_in = 0, mem_write_en_in = 0;
   logic [31:0] alu_res_in = 0, val_Rm_in = 0;
   logic [3:0] dest_in = 0;
   logic ready, wb_en, mem_read_en, addr_err;
   logic [31:0] alu_res, mem_data;
   logic [3:0] dest;
   int cmp = 0, bad = 0;
   logic [31:0] m [D];
   logic [31:0] md = 0;
   logic er = 0;

   mem_stage #(.DEPTH(D), .WAIT_CYCLES(W), .BASE_ADDR(B)) dut (
      .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_read_en_in(mem_read_en_in),
      .mem_write_en_in(mem_write_en_in), .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in),
      .dest_in(dest_in), .ready(ready), .wb_en(wb_en), .mem_read_en(mem_read_en),
      .alu_res(alu_res), .mem_data(mem_data), .dest(dest), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
      cmp++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", t, o, e);
      end
   endtask

   function automatic bit oor(input logic [31:0] a);
      return a < 32'(B) || (a - 32'(B)) / 4 >= 32'(D);
   endfunction

   task automatic drive(input bit r, input bit w, input bit wb, input logic [31:0] a, input logic [31:0] d, input logic [3:0] ds);
      @(negedge clk);
      mem_read_en_in = r;
      mem_write_en_in = w;
      wb_en_in = wb;
      alu_res_in = a;
      val_Rm_in = d;
      dest_in = ds;
   endtask

   task automatic op(input bit r, input bit w, input bit wb, input logic [31:0] a, input logic [31:0] d, input logic [3:0] ds);
      int n = 0;
      drive(r, w, wb, a, d, ds);
      #1;
      if (!(r || w)) begin
         chk("pass_ready", ready, 1);
         chk("pass_wb", wb_en, wb);
         chk("pass_mre", mem_read_en, 0);
         chk("pass_alu", alu_res, a);
         chk("pass_dest", dest, ds);
         return;
      end
      while (ready !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk("stall_len", n, W + 1);
      if (oor(a)) begin
         er = 1;
         if (!w) md = 0;
      end else if (w) m[int'((a - 32'(B)) / 4)] = d;
      else md = m[int'((a - 32'(B)) / 4)];
      chk("done_ready", ready, 1);
      chk("done_wb", wb_en, wb);
      chk("done_mre", mem_read_en, r);
      chk("done_alu", alu_res, a);
      chk("done_dest", dest, ds);
      chk("done_mdata", mem_data, md);
      chk("done_err", addr_err, er);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1;
      op(0, 0, 1, 32'h55, 0, 4'h3);
      chk("rst_mdata", mem_data, 0);
      chk("rst_err", addr_err, 0);
      for (int i = 0; i < D; i++) op(0, 1, 0, 32'(B + 4 * i), $urandom, 4'(i));
      op(0, 1, 0, 1032, 32'hDEADBEEF, 4'h1);
      op(1, 0, 1, 1032, 0, 4'h2);
      op(1, 0, 1, 1035, 0, 4'h5);
      op(0, 1, 0, 1028, 32'hA5A5A5A5, 4'h0);
      drive(0, 1, 0, 1028, 32'h1234, 4'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      #1;
      md = 0;
      er = 0;
      chk("abort_ready", ready, 0);
      chk("abort_mdata", mem_data, 0);
      chk("abort_err", addr_err, 0);
      drive(0, 0, 0, 0, 0, 0);
      rst = 1;
      #1;
      chk("post_rst_ready", ready, 1);
      op(1, 0, 1, 1028, 0, 4'h7);
      for (int k = 0; k < 60; k++) begin
         logic [31:0] a;
         bit r, w;
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0: a = 32'($urandom_range(0, B - 1));
            1: a = 32'(B + 4 * D + $urandom_range(0, 200));
            default: a = 32'(B + $urandom_range(0, 4 * D - 1));
         endcase
         op(r, w, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
      op(1, 0, 1, 1036, 0, 4'h8);
      op(1, 1, 1, 1036, 32'hCAFEF00D, 4'h9);
      op(1, 0, 0, 1036, 0, 4'hA);
      op(0, 1, 0, 1020, 32'h11111111, 4'h0);
      op(0, 1, 0, 32'(B + 4 * D), 32'h22222222, 4'h0);
      op(1, 0, 1, 1020, 0, 4'hB);
      op(1, 0, 1, 32'(B + 4 * D - 4), 0, 4'hC);
      op(0, 0, 1, 32'h99, 0, 4'hD);
      chk("final_err", addr_err, er);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
